ata_pio_timing: RTL and testbench

ATA_PIO_TIMING -- requirements
Module: ata_pio_timing

---
 rtl/ata_pio_timing.sv | 129 ++++++++++++
 tb/tb_ata_pio_timing.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ata_pio_timing.sv
// ata_pio_timing: ATA PIO read/write strobe sequencer with IORDY wait states for a 68040 bus.
module ata_pio_timing (
    input  logic       CLK40,
    input  logic       RESET,
    input  logic       TSn,
    input  logic       ATA_ENn,
    input  logic       RnW,
    input  logic [2:0] PIO_MODE,
    input  logic       IORDY,
    output logic       DIORn,
    output logic       DIOWn,
    output logic       ATA_TACKn,
    output logic       BUSY,
    output logic       TIMEOUT
);
    typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, RECOVER} state_t;
    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [4:0]  r_act;
    logic [4:0]  r_rec;
    logic [7:0]  r_wcnt;
    logic        r_ext;
    logic        r_pend;
    logic        r_prnw;
    logic        r_rnw;
    logic [2:0]  r_pmode;
    logic [1:0]  r_sync;
    logic        w_req;
    logic        w_iordy;
    logic        w_nrnw;
    logic [2:0]  w_nmode;
    logic [14:0] w_ntim;

    // {setup-1, active-1, recovery-1} in CLK40 clocks
    function automatic logic [14:0] f_tim(input logic [2:0] m);
        case (m)
            3'd1:    return {5'd1, 5'd5, 5'd7};
            3'd2:    return {5'd1, 5'd3, 5'd4};
            3'd3:    return {5'd1, 5'd2, 5'd2};
            3'd4:    return {5'd0, 5'd2, 5'd0};
            default: return {5'd2, 5'd6, 5'd13};
        endcase
    endfunction

    function automatic logic [2:0] f_dec(input logic [2:0] m);
        return (m > 3'd4) ? 3'd0 : m;
    endfunction

    assign w_req   = ~TSn & ~ATA_ENn;
    assign w_iordy = r_sync[1];
    assign w_nmode = r_pend ? r_pmode : f_dec(PIO_MODE);
    assign w_nrnw  = r_pend ? r_prnw : RnW;
    assign w_ntim  = f_tim(w_nmode);

    always_ff @(posedge CLK40 or posedge RESET) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_act     <= '0;
            r_rec     <= '0;
            r_wcnt    <= '0;
            r_ext     <= 1'b0;
            r_pend    <= 1'b0;
            r_prnw    <= 1'b0;
            r_rnw     <= 1'b0;
            r_pmode   <= '0;
            r_sync    <= '0;
            DIORn     <= 1'b1;
            DIOWn     <= 1'b1;
            ATA_TACKn <= 1'b1;
            BUSY      <= 1'b0;
            TIMEOUT   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], IORDY};
            ATA_TACKn <= 1'b1;
            if (w_req && r_state != IDLE && !r_pend && !(r_state == RECOVER && r_cnt == 5'd0)) begin
                r_pend  <= 1'b1;
                r_pmode <= f_dec(PIO_MODE);
                r_prnw  <= RnW;
            end
            case (r_state)
                IDLE, RECOVER: begin
                    if (r_state == RECOVER && r_cnt != 5'd0)
                        r_cnt <= r_cnt - 5'd1;
                    else if (w_req || r_pend) begin
                        r_state <= SETUP;
                        BUSY    <= 1'b1;
                        r_rnw   <= w_nrnw;
                        r_cnt   <= w_ntim[14:10];
                        r_act   <= w_ntim[9:5];
                        r_rec   <= w_ntim[4:0];
                        r_pend  <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                        BUSY    <= 1'b0;
                    end
                end
                SETUP: begin
                    if (r_cnt == 5'd0) begin
                        r_state <= ACTIVE;
                        r_cnt   <= r_act;
                        DIORn   <= ~r_rnw;
                        DIOWn   <= r_rnw;
                    end else
                        r_cnt <= r_cnt - 5'd1;
                end
                ACTIVE: begin
                    if (r_cnt != 5'd0)
                        r_cnt <= r_cnt - 5'd1;
                    // first stalled clock only arms r_ext, so the cap lands 256 clocks later
                    else if (!w_iordy && !(r_ext && &r_wcnt)) begin
                        r_ext  <= 1'b1;
                        r_wcnt <= r_wcnt + {7'd0, r_ext};
                    end else begin
                        r_state   <= RECOVER;
                        r_cnt     <= r_rec;
                        DIORn     <= 1'b1;
                        DIOWn     <= 1'b1;
                        ATA_TACKn <= 1'b0;
                        r_ext     <= 1'b0;
                        r_wcnt    <= '0;
                        TIMEOUT   <= TIMEOUT | ~w_iordy;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ata_pio_timing.sv
// tb_ata_pio_timing: table-driven and randomized checks of ata_pio_timing against a timing-rule model.
`timescale 1ns/1ps
module tb_ata_pio_timing;
    logic       CLK40 = 1'b0;
    logic       RESET = 1'b1;
    logic       TSn = 1'b1;
    logic       ATA_ENn = 1'b1;
    logic       RnW = 1'b0;
    logic [2:0] PIO_MODE = 3'd0;
    logic       IORDY = 1'b1;
    logic       DIORn, DIOWn, ATA_TACKn, BUSY, TIMEOUT;

    ata_pio_timing dut (
        .CLK40(CLK40), .RESET(RESET), .TSn(TSn), .ATA_ENn(ATA_ENn), .RnW(RnW),
        .PIO_MODE(PIO_MODE), .IORDY(IORDY), .DIORn(DIORn), .DIOWn(DIOWn),
        .ATA_TACKn(ATA_TACKn), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
    );

    always #12.5 CLK40 = ~CLK40;

    // all edges relative to the first request; r2 < 0 means no second request
    typedef struct {
        int m; bit rnw; int r2; int m2; bit rnw2; int ilo; int ilen;
        int s1; int e1; int i1; int s2; int e2; int i2; int toe;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    bit   g_to = 1'b0;
    int   cur_ilo = 0;
    int   cur_ilen = 0;
    int   ts[5] = '{3, 2, 2, 2, 1};
    int   ta[5] = '{7, 6, 4, 3, 3};
    int   tr[5] = '{14, 8, 5, 3, 1};
    vec_t tbl[15];

    function automatic bit ivs(input int x);
        return !(x >= cur_ilo && x < cur_ilo + cur_ilen);
    endfunction

    // strobe release edge: first edge whose synchronised IORDY (sampled two edges back) is high, capped at +256
    function automatic int rel(input int e0);
        for (int e = e0; e <= e0 + 256; e++)
            if (ivs(e - 2)) return e;
        return e0 + 256;
    endfunction

    function automatic int md(input int m);
        return (m > 4) ? 0 : m;
    endfunction

    task automatic check(input string nm, input logic [4:0] exp);
        logic [4:0] act;
        act = {DIORn, DIOWn, ATA_TACKn, BUSY, TIMEOUT};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {rd,wr,tack,busy,to}=%b want %b", nm, act, exp);
        end
    endtask

    task automatic step(input logic tsn, input logic en, input logic rnw, input logic [2:0] m);
        TSn = tsn; ATA_ENn = en; RnW = rnw; PIO_MODE = m;
        @(posedge CLK40); #1;
    endtask

    task automatic run_trial(input int id, input vec_t v);
        bit h2;
        int last;
        int r;
        bit low1, low2;
        logic [4:0] exp;
        h2 = v.r2 >= 0;
        last = (h2 ? v.i2 : v.i1) + 2;
        cur_ilo = v.ilo;
        cur_ilen = v.ilen;
        for (int n = 0; n <= last + 2; n++) begin
            r = n - 2;
            if (r == 0 || (h2 && r == v.r2)) begin
                TSn = 1'b0; ATA_ENn = 1'b0;
                RnW = (r == 0) ? v.rnw : v.rnw2;
                PIO_MODE = (r == 0) ? 3'(v.m) : 3'(v.m2);
            end else begin
                ATA_ENn = 1'($urandom);
                TSn = ATA_ENn ? 1'($urandom) : 1'b1;
                RnW = 1'($urandom);
                PIO_MODE = 3'($urandom);
            end
            IORDY = ivs(r);
            @(posedge CLK40); #1;
            low1 = r >= v.s1 && r < v.e1;
            low2 = h2 && r >= v.s2 && r < v.e2;
            exp[4] = !((low1 && v.rnw) || (low2 && v.rnw2));
            exp[3] = !((low1 && !v.rnw) || (low2 && !v.rnw2));
            exp[2] = !(r == v.e1 || (h2 && r == v.e2));
            exp[1] = r >= 0 && r < (h2 ? v.i2 : v.i1);
            exp[0] = g_to || (v.toe >= 0 && r >= v.toe);
            check($sformatf("trial%0d edge%0d", id, r), exp);
        end
        IORDY = 1'b1;
        if (v.toe >= 0) g_to = 1'b1;
    endtask

    task automatic rand_vec(output vec_t v);
        int a, b;
        v.m = int'($urandom % 8); v.rnw = 1'($urandom);
        v.m2 = int'($urandom % 8); v.rnw2 = 1'($urandom);
        v.ilo = int'($urandom % 20);
        v.ilen = ($urandom % 3 == 0) ? 1 + int'($urandom % 25) : 0;
        cur_ilo = v.ilo; cur_ilen = v.ilen;
        v.toe = -1;
        a = md(v.m);
        v.s1 = ts[a];
        v.e1 = rel(v.s1 + ta[a]);
        if (!ivs(v.e1 - 2)) v.toe = v.e1;
        v.i1 = v.e1 + tr[a];
        v.r2 = -1; v.s2 = 0; v.e2 = 0; v.i2 = 0;
        if ($urandom % 2 == 1) begin
            v.r2 = 1 + int'($urandom % v.i1);
            b = md(v.m2);
            v.s2 = v.i1 + ts[b];
            v.e2 = rel(v.s2 + ta[b]);
            if (v.toe < 0 && !ivs(v.e2 - 2)) v.toe = v.e2;
            v.i2 = v.e2 + tr[b];
        end
    endtask

    initial begin
        vec_t v;
        tbl[0]  = '{0, 1, -1, 0, 0, 0, 0,   3, 10, 24,  0,  0,  0, -1};
        tbl[1]  = '{0, 0, -1, 0, 0, 0, 0,   3, 10, 24,  0,  0,  0, -1};
        tbl[2]  = '{1, 1, -1, 0, 0, 0, 0,   2,  8, 16,  0,  0,  0, -1};
        tbl[3]  = '{2, 0, -1, 0, 0, 0, 0,   2,  6, 11,  0,  0,  0, -1};
        tbl[4]  = '{3, 1, -1, 0, 0, 0, 0,   2,  5,  8,  0,  0,  0, -1};
        tbl[5]  = '{4, 1, -1, 0, 0, 0, 0,   1,  4,  5,  0,  0,  0, -1};
        tbl[6]  = '{4, 0, -1, 0, 0, 0, 0,   1,  4,  5,  0,  0,  0, -1};
        tbl[7]  = '{5, 1, -1, 0, 0, 0, 0,   3, 10, 24,  0,  0,  0, -1};
        tbl[8]  = '{7, 0, -1, 0, 0, 0, 0,   3, 10, 24,  0,  0,  0, -1};
        tbl[9]  = '{0, 1, 15, 3, 0, 0, 0,   3, 10, 24, 26, 29, 32, -1};
        tbl[10] = '{2, 0,  3, 3, 1, 0, 0,   2,  6, 11, 13, 16, 19, -1};
        tbl[11] = '{4, 1,  5, 1, 0, 0, 0,   1,  4,  5,  7, 13, 21, -1};
        tbl[12] = '{2, 1, -1, 0, 0, 4, 10,  2, 16, 21,  0,  0,  0, -1};
        tbl[13] = '{1, 0, -1, 0, 0, 0, 300, 2, 264, 272, 0, 0,  0, 264};
        tbl[14] = '{6, 1, -1, 0, 0, 0, 0,   3, 10, 24,  0,  0,  0, -1};

        repeat (2) @(posedge CLK40);
        #1;
        check("reset_state", 5'b11100);
        RESET = 1'b0;

        for (int i = 0; i < 15; i++) run_trial(i, tbl[i]);

        // reset mid-read with a pending request queued behind it
        step(1'b0, 1'b0, 1'b1, 3'd0);
        check("rst_seq setup", {4'b1111, g_to});
        step(1'b1, 1'b1, 1'b0, 3'd0);
        step(1'b0, 1'b0, 1'b0, 3'd4);
        step(1'b1, 1'b1, 1'b0, 3'd0);
        check("rst_seq strobe", {4'b0111, g_to});
        #3 RESET = 1'b1;
        #1 check("rst_seq async", 5'b11100);
        g_to = 1'b0;
        @(posedge CLK40); #1;
        check("rst_seq held", 5'b11100);
        RESET = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b1, 1'b0, 3'd0);
            check($sformatf("rst_seq idle%0d", i), 5'b11100);
        end
        run_trial(100, tbl[5]);

        for (int i = 0; i < 40; i++) begin
            rand_vec(v);
            run_trial(200 + i, v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
